// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate truth-table checker.
// State encoding, vector count and hold-timer width live here.
package gate_chk_pkg;

  localparam int NUM_VEC = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
  } chk_stat_t;

  localparam chk_stat_t STAT_RST = '0;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Bundle between the checker and the gate under test / controller.
// master = checker side, slave = environment side.
interface gate_truth_checker_if #(
  parameter int CNT_W = 3
);

  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       fail_mask;

  modport master (
    input  start,
    input  c,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_mask
  );

  modport slave (
    output start,
    output c,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_mask
  );

endinterface

// File: rtl/gate_truth_checker_hold.sv
// Settle-time counter: expire fires on the last of HOLD_CYCLES
// enabled cycles; the count returns to zero on load or expire.
module gate_hold_timer
  import gate_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam logic [HOLD_W-1:0] LAST =
    HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps {a,b} through 00..11, samples c after a settle time and
// compares against TRUTH; reports pass, error count and fail mask.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH       = 4'b1000,
  parameter int         HOLD_CYCLES = 4,
  parameter int         CNT_W       = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_truth_checker_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [1:0]       ab, ab_nxt;
  logic [CNT_W-1:0] err, err_nxt;
  chk_stat_t        stat, stat_nxt;

  logic tmr_load;
  logic tmr_en;
  logic tmr_exp;
  logic miss;

  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .enable (tmr_en),
    .expire (tmr_exp)
  );

  assign miss = (bus.c != TRUTH[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      ab    <= '0;
      err   <= '0;
      stat  <= STAT_RST;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ab    <= ab_nxt;
      err   <= err_nxt;
      stat  <= stat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ab_nxt    = ab;
    err_nxt   = err;
    stat_nxt  = stat;
    tmr_load  = 1'b1;
    tmr_en    = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          ab_nxt    = '0;
          err_nxt   = '0;
          stat_nxt  = STAT_RST;
        end
      end
      DRIVE: begin
        tmr_load = 1'b0;
        tmr_en   = 1'b1;
        if (tmr_exp) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (miss) begin
          stat_nxt.fail_mask[idx] = 1'b1;
          if (err != CNT_MAX) begin
            err_nxt = err + 1'b1;
          end
        end
        // last vector: verdict uses the count including this compare
        if (idx == 2'(NUM_VEC - 1)) begin
          state_nxt     = DONE;
          ab_nxt        = '0;
          stat_nxt.done = 1'b1;
          stat_nxt.pass = (err_nxt == '0);
        end else begin
          state_nxt = DRIVE;
          idx_nxt   = idx + 1'b1;
          ab_nxt    = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    stat_nxt.busy = (state_nxt == DRIVE) ||
                    (state_nxt == SAMPLE);
  end

  assign bus.a         = ab[1];
  assign bus.b         = ab[0];
  assign bus.busy      = stat.busy;
  assign bus.done      = stat.done;
  assign bus.pass      = stat.pass;
  assign bus.err_cnt   = err;
  assign bus.fail_mask = stat.fail_mask;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench: three checker instances against table-driven gate models.
// Expected results come from mismatch = gate ^ TRUTH.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic       st  [3];
  logic [3:0] tbl [3];
  logic       dn  [3];
  logic       bs  [3];
  logic       ps  [3];
  logic [1:0] ab  [3];
  logic [3:0] fm  [3];
  int         ec  [3];

  logic [3:0] truth [3];
  int         hold  [3];
  int         maxc  [3];

  gate_truth_checker_if #(.CNT_W(3)) if0 ();
  gate_truth_checker_if #(.CNT_W(1)) if1 ();
  gate_truth_checker_if #(.CNT_W(3)) if2 ();

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.c = tbl[0][{if0.a, if0.b}];
  assign if1.c = tbl[1][{if1.a, if1.b}];
  assign if2.c = tbl[2][{if2.a, if2.b}];

  gate_truth_checker #(
    .TRUTH(4'b1000), .HOLD_CYCLES(4), .CNT_W(3)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  gate_truth_checker #(
    .TRUTH(4'b1000), .HOLD_CYCLES(4), .CNT_W(1)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  gate_truth_checker #(
    .TRUTH(4'b0110), .HOLD_CYCLES(1), .CNT_W(3)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always_comb begin
    dn[0] = if0.done; bs[0] = if0.busy; ps[0] = if0.pass;
    dn[1] = if1.done; bs[1] = if1.busy; ps[1] = if1.pass;
    dn[2] = if2.done; bs[2] = if2.busy; ps[2] = if2.pass;
    ab[0] = {if0.a, if0.b};
    ab[1] = {if1.a, if1.b};
    ab[2] = {if2.a, if2.b};
    fm[0] = if0.fail_mask;
    fm[1] = if1.fail_mask;
    fm[2] = if2.fail_mask;
    ec[0] = int'(if0.err_cnt);
    ec[1] = int'(if1.err_cnt);
    ec[2] = int'(if2.err_cnt);
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic sweep(input int id, input logic [3:0] gate,
                       input int repulse, input string tag);
    int h, lat, bad, j, cnt, exp_err;
    logic [3:0] mism;
    h = hold[id];
    lat = 4 * (h + 1);
    mism = gate ^ truth[id];
    cnt = $countones(mism);
    exp_err = (cnt > maxc[id]) ? maxc[id] : cnt;
    tbl[id] = gate;
    @(negedge clk);
    st[id] = 1'b1;
    @(posedge clk);
    #1;
    st[id] = 1'b0;
    chk({tag, "_acc_done"}, int'(dn[id]), 0);
    chk({tag, "_acc_busy"}, int'(bs[id]), 1);
    bad = 0;
    j = 0;
    while (!dn[id] && j < 200) begin
      @(posedge clk);
      #1;
      j++;
      st[id] = (j == repulse);
      if (!dn[id] && ab[id] != 2'(j / (h + 1))) bad++;
      if (!dn[id] && !bs[id]) bad++;
    end
    st[id] = 1'b0;
    chk({tag, "_latency"}, j, lat);
    chk({tag, "_ab_seq"}, bad, 0);
    chk({tag, "_err_cnt"}, ec[id], exp_err);
    chk({tag, "_fail_mask"}, int'(fm[id]), int'(mism));
    chk({tag, "_pass"}, int'(ps[id]), int'(cnt == 0));
    chk({tag, "_end_ab"}, int'(ab[id]), 0);
    chk({tag, "_end_busy"}, int'(bs[id]), 0);
  endtask

  typedef struct {
    string      name;
    logic [3:0] gate;
    int         e_err;
    logic [3:0] e_mask;
    logic       e_pass;
  } vec_t;

  vec_t vt [6];

  initial begin
    truth = '{4'b1000, 4'b1000, 4'b0110};
    hold  = '{4, 4, 1};
    maxc  = '{7, 1, 7};
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      tbl[i] = 4'b0000;
    end

    vt[0] = '{"and_nor", 4'b1000, 0, 4'b0000, 1'b1};
    vt[1] = '{"or",      4'b1110, 2, 4'b0110, 1'b0};
    vt[2] = '{"tie1",    4'b1111, 3, 4'b0111, 1'b0};
    vt[3] = '{"tie0",    4'b0000, 1, 4'b1000, 1'b0};
    vt[4] = '{"xor",     4'b0110, 3, 4'b1110, 1'b0};
    vt[5] = '{"nand",    4'b0111, 4, 4'b1111, 1'b0};

    #12;
    chk("rst_busy", int'(bs[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_pass", int'(ps[0]), 0);
    chk("rst_err", ec[0], 0);
    chk("rst_mask", int'(fm[0]), 0);
    chk("rst_ab", int'(ab[0]), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // start lands on the first edge after release
    for (int i = 0; i < 6; i++) begin
      sweep(0, vt[i].gate, -1, vt[i].name);
      chk({vt[i].name, "_tbl_err"}, ec[0], vt[i].e_err);
      chk({vt[i].name, "_tbl_mask"}, int'(fm[0]),
          int'(vt[i].e_mask));
      chk({vt[i].name, "_tbl_pass"}, int'(ps[0]),
          int'(vt[i].e_pass));
    end

    sweep(1, 4'b1111, -1, "sat1");
    chk("sat1_err", ec[1], 1);

    sweep(0, 4'b1000, 11, "restart_ign");

    sweep(2, 4'b0110, -1, "h1_first");
    @(negedge clk);
    chk("h1_done_held", int'(dn[2]), 1);
    sweep(2, 4'b1001, -1, "h1_restart");

    for (int k = 0; k < 12; k++) begin
      int id;
      logic [3:0] g;
      id = int'($urandom_range(0, 2));
      g = 4'($urandom);
      sweep(id, g, -1, $sformatf("rnd%0d", k));
    end

    // reset during SAMPLE of vector 1
    @(negedge clk);
    tbl[0] = 4'b1111;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_ab", int'(ab[0]), 1);
    chk("mid_err", ec[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bs[0]), 0);
    chk("mid_rst_err", ec[0], 0);
    chk("mid_rst_mask", int'(fm[0]), 0);
    chk("mid_rst_ab", int'(ab[0]), 0);
    chk("mid_rst_done", int'(dn[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep(0, 4'b1000, -1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
